// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, XLEN iterations.
// Optional `define MULDIV_EARLY_OUT_EN finishes divide-by-zero and signed overflow in two cycles.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            Start,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] OpA,
   input  logic [XLEN-1:0] OpB,
   input  logic [4:0]      RdIn,
   output logic            Busy,
   output logic            Done,
   output logic            RegWEn,
   output logic [4:0]      AddrD,
   output logic [XLEN-1:0] DataD
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic              neg_q, neg_d;
   logic              special_q, special_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   data_q, data_d;

   logic              is_div;
   logic              a_signed, b_signed;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   spec_val;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] div_next;

   logic [2*XLEN-1:0] mul_res;
   logic [XLEN-1:0]   div_sel, div_res, final_res;

   // Operand decode at accept time: magnitudes are XLEN-bit unsigned, so the
   // most-negative value maps cleanly to 2**(XLEN-1).
   always_comb begin
      is_div   = Funct3[2];
      a_signed = (Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
                 (Funct3 == OP_DIV)  || (Funct3 == OP_REM);
      b_signed = (Funct3 == OP_MULH) || (Funct3 == OP_DIV) || (Funct3 == OP_REM);
      a_neg    = a_signed && OpA[XLEN-1];
      b_neg    = b_signed && OpB[XLEN-1];
      abs_a    = a_neg ? -OpA : OpA;
      abs_b    = b_neg ? -OpB : OpB;
      div_zero = is_div && (OpB == '0);
      div_ovf  = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
                 (OpA == {1'b1, {(XLEN-1){1'b0}}}) && (OpB == '1);
      special  = div_zero || div_ovf;
      if (div_zero) begin
         spec_val = Funct3[1] ? OpA : '1;
      end else begin
         spec_val = Funct3[1] ? '0 : OpA;
      end
   end

   // One iteration of each algorithm; prod_q holds {acc, multiplier} or {rem, quo}.
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
      mul_next  = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                            : {1'b0, prod_q[2*XLEN-1:1]};
      div_shift = prod_q[2*XLEN-1:XLEN-1];
      div_ge    = div_shift >= {1'b0, opnd_q};
      div_diff  = div_shift[XLEN-1:0] - opnd_q;
      div_next  = div_ge ? {div_diff, prod_q[XLEN-2:0], 1'b1}
                         : {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
   end

   always_comb begin
      mul_res = neg_q ? -prod_q : prod_q;
      div_sel = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
      div_res = neg_q ? -div_sel : div_sel;
      if (op_q[2]) begin
         final_res = div_res;
      end else if (op_q == OP_MUL) begin
         final_res = mul_res[XLEN-1:0];
      end else begin
         final_res = mul_res[2*XLEN-1:XLEN];
      end
   end

   // Special cases preload the result into both halves of prod_q and freeze it,
   // so the finishing step needs no extra mux.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      opnd_d    = opnd_q;
      prod_d    = prod_q;
      neg_d     = neg_q;
      special_d = special_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               state_d   = CALC;
               op_d      = Funct3;
               rd_d      = RdIn;
               special_d = special;
               if (special) begin
                  prod_d = {spec_val, spec_val};
                  opnd_d = '0;
                  neg_d  = 1'b0;
               end else if (is_div) begin
                  prod_d = {{XLEN{1'b0}}, abs_a};
                  opnd_d = abs_b;
                  neg_d  = Funct3[1] ? a_neg : (a_neg ^ b_neg);
               end else begin
                  prod_d = {{XLEN{1'b0}}, abs_b};
                  opnd_d = abs_a;
                  neg_d  = a_neg ^ b_neg;
               end
`ifdef MULDIV_EARLY_OUT_EN
               cnt_d = special ? CW'(XLEN) : '0;
`else
               cnt_d = '0;
`endif
            end
         end
         CALC: begin
            if (cnt_q == CW'(XLEN)) begin
               data_d  = final_res;
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (!special_q) begin
                  prod_d = op_q[2] ? div_next : mul_next;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         opnd_q    <= '0;
         prod_q    <= '0;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         cnt_q     <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         opnd_q    <= opnd_d;
         prod_q    <= prod_d;
         neg_q     <= neg_d;
         special_q <= special_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
      end
   end

   assign Busy   = (state_q != IDLE);
   assign Done   = (state_q == FIN);
   assign RegWEn = Done && (rd_q != 5'd0);
   assign AddrD  = rd_q;
   assign DataD  = data_q;

endmodule
